// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with returning load data
// onto one registered register-file write port. Loads are buffered in a small
// in-order FIFO, and a pending scoreboard flags destinations with loads in flight.
module writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_resp_valid,
  input  logic [4:0]  ld_resp_rd,
  input  logic [31:0] ld_resp_data,
  output logic        ld_resp_ready,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic        busy1,
  output logic        busy2,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        WE3,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t          fifo [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic [31:0]      pending, pend_nxt;
  wb_ent_t          head;
  logic             alu_req, accept, push, pop;
  logic             issue_v, issue_viol, resp_viol;

  // Credit is based on the registered count only; a pop this cycle frees
  // a slot that becomes visible next cycle.
  assign ld_resp_ready = (count < CW'(DEPTH));
  assign alu_req       = alu_valid && (alu_rd != 5'd0);
  assign accept        = ld_resp_valid && ld_resp_ready;
  assign push          = accept && (ld_resp_rd != 5'd0);
  // Registered count means an entry pushed this edge cannot pop until next cycle.
  assign pop           = !alu_req && (count != '0);
  assign head          = fifo[rptr];

  assign issue_v    = ld_issue && (ld_issue_rd != 5'd0);
  assign issue_viol = issue_v && pending[ld_issue_rd];
  assign resp_viol  = push && !pending[ld_resp_rd];

  // Bit 0 is never set, so address 0 reads as not busy.
  assign busy1 = pending[A1];
  assign busy2 = pending[A2];

  // Scoreboard next state: clear on pop, then set, so a same-rd set wins.
  always_comb begin
    pend_nxt = pending;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (issue_v) pend_nxt[ld_issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{rd: ld_resp_rd, data: ld_resp_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending scoreboard and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (issue_viol || resp_viol) err <= 1'b1;
    end
  end

  // Registered write port: ALU has priority, FIFO head otherwise; A3/WD3 hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= alu_req || pop;
      if (alu_req) begin
        A3  <= alu_rd;
        WD3 <= alu_result;
      end else if (pop) begin
        A3  <= head.rd;
        WD3 <= head.data;
      end
    end
  end

endmodule
